// File: rtl/hard_png_writer.sv
// Streaming PNG encoder: signature, IHDR, one stored-deflate IDAT per raster row, IEND.
// A single registered output slot carries every byte; CRC-32 and Adler-32 track the emitted bytes.
module hard_png_writer #(
   parameter int ALPHA = 1
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        start,
   input  logic [13:0] width,
   input  logic [31:0] height,
   output logic        busy,
   input  logic        ivalid,
   output logic        iready,
   input  logic [7:0]  ipixelr,
   input  logic [7:0]  ipixelg,
   input  logic [7:0]  ipixelb,
   input  logic [7:0]  ipixela,
   output logic        ovalid,
   input  logic        oready,
   output logic [7:0]  obyte,
   output logic        olast
);
   // state  | meaning
   // IDLE   | waiting for an accepted start
   // SIG    | 8-byte PNG signature
   // IHDR   | IHDR chunk including its CRC
   // ROWHDR | IDAT length/type, zlib header (first row), stored-block header
   // FILT   | filter-type byte 00
   // PIX    | pixel components R,G,B(,A)
   // ADLER  | zlib Adler-32 trailer (last row only)
   // DCRC   | IDAT CRC
   // IEND   | fixed IEND chunk, then wait for the final byte to leave
   typedef enum logic [3:0] {
      S_IDLE, S_SIG, S_IHDR, S_ROWHDR, S_FILT, S_PIX, S_ADLER, S_DCRC, S_IEND
   } state_t;

   localparam int         NC         = (ALPHA != 0) ? 4 : 3;
   localparam logic [1:0] LAST_COMP  = 2'(NC - 1);
   localparam logic [7:0] COLOR_TYPE = (ALPHA != 0) ? 8'h06 : 8'h02;
   localparam logic [63:0] SIG_BYTES  = 64'h89504E470D0A1A0A;
   localparam logic [95:0] IEND_BYTES = 96'h0000000049454E44AE426082;

   state_t      state_q, state_d;
   logic [15:0] idx_q, idx_d;
   logic [13:0] col_q, col_d, width_q, width_d;
   logic [31:0] row_q, row_d, height_q, height_d;
   logic [1:0]  comp_q, comp_d;
   logic [23:0] pix_q, pix_d;
   logic [31:0] crc_q, crc_d;
   logic [15:0] s1_q, s1_d, s2_q, s2_d;
   logic        busy_q, busy_d, ovalid_q, ovalid_d, olast_q, olast_d;
   logic [7:0]  obyte_q, obyte_d;

   logic        adv, fire, last_v, upd_crc, crc_init, upd_adl, first_row, last_row;
   logic [7:0]  byte_v;
   logic [15:0] r_len;
   logic [31:0] idat_len, crc_fin;
   logic [167:0] ihdr_vec;

   function automatic logic [7:0] be_byte(input logic [31:0] v, input logic [1:0] k);
      return v[{~k, 3'b000} +: 8];
   endfunction

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] x;
      x = c ^ {24'h0, b};
      for (int i = 0; i < 8; i++) x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
      return x;
   endfunction

   function automatic logic [31:0] adler_byte(input logic [15:0] s1, input logic [15:0] s2,
                                              input logic [7:0] b);
      logic [16:0] a1, a2;
      a1 = {1'b0, s1} + {9'h0, b};
      if (a1 >= 17'd65521) a1 = a1 - 17'd65521;
      a2 = {1'b0, s2} + a1;
      if (a2 >= 17'd65521) a2 = a2 - 17'd65521;
      return {a2[15:0], a1[15:0]};
   endfunction

   assign adv       = !ovalid_q || oready;
   assign first_row = (row_q == 32'd0);
   assign last_row  = (row_q == height_q - 32'd1);
   assign r_len     = 16'd1 + 16'(NC) * {2'b00, width_q};
   assign idat_len  = {16'h0, r_len} + 32'd5 + (first_row ? 32'd2 : 32'd0) + (last_row ? 32'd4 : 32'd0);
   assign crc_fin   = ~crc_q;
   assign ihdr_vec  = {32'h0000000D, 32'h49484452, 18'h0, width_q, height_q,
                       8'h08, COLOR_TYPE, 24'h0};
   assign iready    = (state_q == S_PIX) && (comp_q == 2'd0) && adv;

   always_comb begin
      state_d = state_q;  idx_d = idx_q;  col_d = col_q;  row_d = row_q;  comp_d = comp_q;
      width_d = width_q;  height_d = height_q;  pix_d = pix_q;
      crc_d = crc_q;  s1_d = s1_q;  s2_d = s2_q;
      ovalid_d = ovalid_q;  obyte_d = obyte_q;  olast_d = olast_q;
      fire = 1'b0;  byte_v = 8'h00;  last_v = 1'b0;
      upd_crc = 1'b0;  crc_init = 1'b0;  upd_adl = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start && width != 14'd0 && height != 32'd0) begin
               state_d = S_SIG;  idx_d = 16'd0;  row_d = 32'd0;
               width_d = width;  height_d = height;
               crc_d = 32'hFFFFFFFF;  s1_d = 16'd1;  s2_d = 16'd0;
            end
         end
         S_SIG: begin
            fire   = 1'b1;
            byte_v = SIG_BYTES[{3'd7 - idx_q[2:0], 3'b000} +: 8];
            if (adv) begin
               idx_d = idx_q + 16'd1;
               if (idx_q[2:0] == 3'd7) begin state_d = S_IHDR; idx_d = 16'd0; end
            end
         end
         S_IHDR: begin
            fire = 1'b1;
            if (idx_q < 16'd21) byte_v = ihdr_vec[{5'd20 - idx_q[4:0], 3'b000} +: 8];
            else                byte_v = be_byte(crc_fin, idx_q[1:0] - 2'd1);
            upd_crc  = (idx_q >= 16'd4) && (idx_q <= 16'd20);
            crc_init = (idx_q == 16'd4);
            if (adv) begin
               idx_d = idx_q + 16'd1;
               if (idx_q == 16'd24) begin state_d = S_ROWHDR; idx_d = 16'd0; end
            end
         end
         S_ROWHDR: begin
            fire = 1'b1;
            case (idx_q[3:0])
               4'd0, 4'd1, 4'd2, 4'd3: byte_v = be_byte(idat_len, idx_q[1:0]);
               4'd4, 4'd5, 4'd6, 4'd7: byte_v = be_byte(32'h49444154, idx_q[1:0]);
               4'd8:    byte_v = 8'h78;
               4'd9:    byte_v = 8'h01;
               4'd10:   byte_v = {7'h0, last_row};
               4'd11:   byte_v = r_len[7:0];
               4'd12:   byte_v = r_len[15:8];
               4'd13:   byte_v = ~r_len[7:0];
               default: byte_v = ~r_len[15:8];
            endcase
            upd_crc  = (idx_q >= 16'd4);
            crc_init = (idx_q == 16'd4);
            if (adv) begin
               idx_d = idx_q + 16'd1;
               // The zlib header exists only in the first IDAT
               if (idx_q == 16'd7 && !first_row) idx_d = 16'd10;
               if (idx_q == 16'd14) begin state_d = S_FILT; idx_d = 16'd0; end
            end
         end
         S_FILT: begin
            fire = 1'b1;  upd_crc = 1'b1;  upd_adl = 1'b1;
            if (adv) begin state_d = S_PIX; col_d = 14'd0; comp_d = 2'd0; end
         end
         S_PIX: begin
            fire    = (comp_q != 2'd0) || ivalid;
            upd_crc = 1'b1;  upd_adl = 1'b1;
            case (comp_q)
               2'd0:    byte_v = ipixelr;
               2'd1:    byte_v = pix_q[23:16];
               2'd2:    byte_v = pix_q[15:8];
               default: byte_v = pix_q[7:0];
            endcase
            if (adv && fire) begin
               if (comp_q == 2'd0) pix_d = {ipixelg, ipixelb, ipixela};
               if (comp_q == LAST_COMP) begin
                  comp_d = 2'd0;
                  if (col_q == width_q - 14'd1) begin
                     col_d = 14'd0;  idx_d = 16'd0;
                     state_d = last_row ? S_ADLER : S_DCRC;
                  end else begin
                     col_d = col_q + 14'd1;
                  end
               end else begin
                  comp_d = comp_q + 2'd1;
               end
            end
         end
         S_ADLER: begin
            fire    = 1'b1;  upd_crc = 1'b1;
            byte_v  = be_byte({s2_q, s1_q}, idx_q[1:0]);
            if (adv) begin
               idx_d = idx_q + 16'd1;
               if (idx_q == 16'd3) begin state_d = S_DCRC; idx_d = 16'd0; end
            end
         end
         S_DCRC: begin
            fire   = 1'b1;
            byte_v = be_byte(crc_fin, idx_q[1:0]);
            if (adv) begin
               idx_d = idx_q + 16'd1;
               if (idx_q == 16'd3) begin
                  idx_d = 16'd0;
                  if (last_row) state_d = S_IEND;
                  else begin state_d = S_ROWHDR; row_d = row_q + 32'd1; end
               end
            end
         end
         S_IEND: begin
            fire   = (idx_q < 16'd12);
            last_v = (idx_q == 16'd11);
            if (fire) byte_v = IEND_BYTES[{4'd11 - idx_q[3:0], 3'b000} +: 8];
            if (adv && fire) idx_d = idx_q + 16'd1;
            if (ovalid_q && oready && olast_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (adv) begin
         ovalid_d = fire;
         olast_d  = fire && last_v;
         if (fire) obyte_d = byte_v;
         if (fire && upd_crc) crc_d = crc_byte(crc_init ? 32'hFFFFFFFF : crc_q, byte_v);
         if (fire && upd_adl) {s2_d, s1_d} = adler_byte(s1_q, s2_q, byte_v);
      end
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;  idx_q <= '0;  col_q <= '0;  row_q <= '0;  comp_q <= '0;
         width_q <= '0;  height_q <= '0;  pix_q <= '0;
         crc_q <= '0;  s1_q <= '0;  s2_q <= '0;
         busy_q <= 1'b0;  ovalid_q <= 1'b0;  obyte_q <= '0;  olast_q <= 1'b0;
      end else begin
         state_q <= state_d;  idx_q <= idx_d;  col_q <= col_d;  row_q <= row_d;  comp_q <= comp_d;
         width_q <= width_d;  height_q <= height_d;  pix_q <= pix_d;
         crc_q <= crc_d;  s1_q <= s1_d;  s2_q <= s2_d;
         busy_q <= busy_d;  ovalid_q <= ovalid_d;  obyte_q <= obyte_d;  olast_q <= olast_d;
      end
   end

   assign busy   = busy_q;
   assign ovalid = ovalid_q;
   assign obyte  = obyte_q;
   assign olast  = olast_q;
endmodule
